// File: rtl/pipemem_io_pkg.sv
// Purpose : Shared constants and helpers for the pipeline MEM-stage memory/IO block.
//           Holds the I/O word-index map, the active-low 7-segment digit table
//           (bit order gfedcba) and the binary-to-two-decimal-digit split.
// Ports   : none (package).
package pipemem_io_pkg;

  // I/O word-index map (idx = addr[6:2] when the I/O select bit is set)
  localparam int IN_BASE    = 0;
  localparam int OUT_BASE   = 8;
  localparam int STATUS_IDX = 15;

  // Active-low segments, bit order gfedcba; entry [d] is the glyph for digit d.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // Only segment g lit: shown on both digits when the value does not fit in 0..99.
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  // Splits 0..99 into {tens, units} BCD nibbles.
  function automatic logic [7:0] bin_to_dec2(input logic [6:0] v);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = 4'(v / 7'd10);
    units = 4'(v % 7'd10);
    return {tens, units};
  endfunction

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    if (d > 4'd9) return SEG_DASH;
    return SEG_TABLE[d];
  endfunction

endpackage

// File: rtl/io_debounce.sv
// Purpose : One switch channel: 2-FF synchroniser, stability counter and the
//           accepted (stable) value. 'changed' is high in the cycle whose clock
//           edge loads a new stable value, so the status bit sets on that same edge.
// Ports   : clock   - clock
//           resetn  - synchronous active-low reset
//           raw     - asynchronous switch bits
//           stable  - debounced value
//           changed - single-cycle flag: stable updates at the coming edge
module io_debounce #(
  parameter int W          = 5,
  parameter int DEB_CYCLES = 16
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic [W-1:0] raw,
  output logic [W-1:0] stable,
  output logic         changed
);

  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

  logic [W-1:0]  sync1;
  logic [W-1:0]  sync2;
  logic [CW-1:0] cnt;
  logic          differs;
  logic          moving;

  assign differs = (sync2 != stable);
  assign moving  = (sync1 != sync2);   // synced value changes at the coming edge

  // The counter would reach DEB_CYCLES-1 on this increment: accept instead.
  assign changed = differs && !moving && (cnt == CW'(DEB_CYCLES - 2));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and the sync1->sync2 chain really is two flops.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      sync1  <= '0;
      sync2  <= '0;
      cnt    <= '0;
      stable <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (!differs || moving) begin
        cnt <= '0;
      end else if (changed) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipemem_io.sv
// Purpose : MEM-stage data RAM plus memory-mapped I/O for the pipeline CPU.
//           addr[IO_BIT]=0 -> word RAM (read-first); =1 -> I/O words:
//           0..N_IN-1 debounced switches (RO), 8..8+N_OUT-1 display regs (RW),
//           15 change-status (clear on read). Reads have one cycle of latency.
// Ports   : clock, resetn (sync, active-low); we/re requests; addr byte address;
//           datain write data; dataout/rd_valid registered read result;
//           sw_in raw switches (ch0 in LSBs); out_regs display registers;
//           seg_high/seg_low active-low tens/units 7-seg digits per display reg.
module pipemem_io
  import pipemem_io_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int RAM_AW     = 5,
  parameter int IO_BIT     = 7,
  parameter int N_IN       = 2,
  parameter int IN_W       = 5,
  parameter int N_OUT      = 3,
  parameter int OUT_W      = 8,
  parameter int DEB_CYCLES = 16
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   we,
  input  logic                   re,
  input  logic [31:0]            addr,
  input  logic [DATA_W-1:0]      datain,
  output logic [DATA_W-1:0]      dataout,
  output logic                   rd_valid,
  input  logic [N_IN*IN_W-1:0]   sw_in,
  output logic [N_OUT*OUT_W-1:0] out_regs,
  output logic [N_OUT*7-1:0]     seg_high,
  output logic [N_OUT*7-1:0]     seg_low
);

  localparam int RAM_DEPTH = 1 << RAM_AW;

  logic                   io_sel;
  logic [4:0]             idx;
  logic [RAM_AW-1:0]      ram_addr;
  logic [DATA_W-1:0]      ram [RAM_DEPTH];
  logic [DATA_W-1:0]      rdata;
  logic [N_IN*IN_W-1:0]   sw_stable;
  logic [N_IN-1:0]        sw_changed;
  logic [N_IN-1:0]        status;
  logic                   status_rd;
  logic                   unused_addr;

  assign io_sel      = addr[IO_BIT];
  assign idx         = addr[6:2];
  assign ram_addr    = addr[RAM_AW+1:2];
  assign status_rd   = re && io_sel && (idx == 5'(STATUS_IDX));
  assign unused_addr = ^{addr[31:IO_BIT+1], addr[1:0]};

  // Switch debouncers, one per channel
  for (genvar g = 0; g < N_IN; g++) begin : g_deb
    io_debounce #(
      .W          (IN_W),
      .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
      .clock   (clock),
      .resetn  (resetn),
      .raw     (sw_in[g*IN_W +: IN_W]),
      .stable  (sw_stable[g*IN_W +: IN_W]),
      .changed (sw_changed[g])
    );
  end

  // Read mux; the registered capture below makes RAM reads read-first.
  // NOTE: rdata gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rdata = '0;
    if (!io_sel) begin
      rdata = ram[ram_addr];
    end else begin
      for (int i = 0; i < N_IN; i++)
        if (idx == 5'(IN_BASE + i)) rdata = DATA_W'(sw_stable[i*IN_W +: IN_W]);
      for (int i = 0; i < N_OUT; i++)
        if (idx == 5'(OUT_BASE + i)) rdata = DATA_W'(out_regs[i*OUT_W +: OUT_W]);
      if (idx == 5'(STATUS_IDX)) rdata = DATA_W'(status);
    end
  end

  // NOTE: the RAM array has no reset so it maps onto block/distributed RAM;
  // only the write is qualified by resetn so reset-cycle requests are dropped.
  always_ff @(posedge clock) begin
    if (resetn && we && !io_sel) ram[ram_addr] <= datain;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      dataout  <= '0;
      rd_valid <= 1'b0;
      out_regs <= '0;
      status   <= '0;
    end else begin
      rd_valid <= re;
      if (re) dataout <= rdata;

      for (int i = 0; i < N_OUT; i++)
        if (we && io_sel && idx == 5'(OUT_BASE + i))
          out_regs[i*OUT_W +: OUT_W] <= datain[OUT_W-1:0];

      // A change arriving in the read cycle survives the clear.
      status <= status_rd ? sw_changed : (status | sw_changed);
    end
  end

  // Display decode: two decimal digits per register, dashes above 99
  for (genvar g = 0; g < N_OUT; g++) begin : g_disp
    logic [OUT_W-1:0] v;
    logic [7:0]       dec;
    logic             over;

    assign v    = out_regs[g*OUT_W +: OUT_W];
    assign over = 32'(v) > 32'd99;
    assign dec  = bin_to_dec2(7'(v));

    assign seg_high[g*7 +: 7] = over ? SEG_DASH : seg_digit(dec[7:4]);
    assign seg_low[g*7 +: 7]  = over ? SEG_DASH : seg_digit(dec[3:0]);
  end

endmodule

// File: tb/tb_pipemem_io.sv
// Purpose : Directed bench for pipemem_io. Reads push their expected word onto a
//           scoreboard queue; an independent monitor pops and compares on every
//           cycle where rd_valid is high.
module tb_pipemem_io;

  localparam int DEB = 16;

  // I/O addresses (bit 7 set, word index in bits 6:2)
  localparam logic [31:0] A_SW0    = 32'h80;
  localparam logic [31:0] A_SW1    = 32'h84;
  localparam logic [31:0] A_DISP0  = 32'hA0;
  localparam logic [31:0] A_DISP2  = 32'hA8;
  localparam logic [31:0] A_IDX11  = 32'hAC;
  localparam logic [31:0] A_STATUS = 32'hBC;
  localparam logic [31:0] A_IDX20  = 32'hD0;

  // Active-low gfedcba glyphs
  localparam logic [6:0] G0 = 7'h40, G2 = 7'h24, G4 = 7'h19,
                         G7 = 7'h78, G9 = 7'h10, GD = 7'h3F;

  logic        clock = 1'b0;
  logic        resetn, we, re;
  logic [31:0] addr, datain, dataout;
  logic        rd_valid;
  logic [9:0]  sw_in;
  logic [23:0] out_regs;
  logic [20:0] seg_high, seg_low;

  typedef struct {
    string       name;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  pipemem_io dut (
    .clock    (clock),
    .resetn   (resetn),
    .we       (we),
    .re       (re),
    .addr     (addr),
    .datain   (datain),
    .dataout  (dataout),
    .rd_valid (rd_valid),
    .sw_in    (sw_in),
    .out_regs (out_regs),
    .seg_high (seg_high),
    .seg_low  (seg_low)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] e);
    re   = 1'b1;
    addr = a;
    exp_q.push_back('{name: name, data: e});
    cycle();
    re = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    we     = 1'b1;
    addr   = a;
    datain = d;
    cycle();
    we = 1'b0;
  endtask

  // Monitor: compare every presented read result with the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (rd_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_rd_valid: rd_valid=1 with no read outstanding, expected 0");
        end else begin
          e = exp_q.pop_front();
          check(e.name, dataout, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    // Reset with write and read requests present: both must be dropped
    resetn = 1'b0;
    we     = 1'b1;
    re     = 1'b1;
    addr   = A_DISP0;
    datain = 32'd42;
    sw_in  = '0;
    repeat (3) cycle();
    resetn = 1'b1;
    we     = 1'b0;
    re     = 1'b0;
    check("reset_out_regs", 32'(out_regs), 32'h0);
    check("reset_seg_high", 32'(seg_high), 32'({G0, G0, G0}));
    check("reset_seg_low",  32'(seg_low),  32'({G0, G0, G0}));
    check("reset_rd_valid", 32'(rd_valid), 32'h0);
    check("reset_dataout",  dataout,       32'h0);
    rd("reset_status", A_STATUS, 32'h0);

    // RAM: write/read, read-first on collision, no aliasing between words
    wr(32'h14, 32'hDEADBEEF);
    rd("ram_rd_w5", 32'h14, 32'hDEADBEEF);
    we = 1'b1; datain = 32'h1;
    rd("ram_read_first", 32'h14, 32'hDEADBEEF);
    we = 1'b0;
    wr(32'h7C, 32'h12345678);
    rd("ram_rd_w31", 32'h7C, 32'h12345678);
    rd("ram_rd_w5_new", 32'h14, 32'h1);
    cycle();
    check("rd_valid_drops", 32'(rd_valid), 32'h0);
    check("dataout_holds",  dataout,       32'h1);

    // Display decode and boundaries
    wr(A_DISP0, 32'd42);
    check("disp42_reg",  32'(out_regs[7:0]),  32'd42);
    check("disp42_high", 32'(seg_high[6:0]),  32'(G4));
    check("disp42_low",  32'(seg_low[6:0]),   32'(G2));
    wr(A_DISP0, 32'd99);
    check("disp99_high", 32'(seg_high[6:0]),  32'(G9));
    check("disp99_low",  32'(seg_low[6:0]),   32'(G9));
    wr(A_DISP0, 32'd100);
    check("disp100_high", 32'(seg_high[6:0]), 32'(GD));
    check("disp100_low",  32'(seg_low[6:0]),  32'(GD));
    wr(A_DISP0, 32'd150);
    check("disp150_high", 32'(seg_high[6:0]), 32'(GD));
    check("disp150_low",  32'(seg_low[6:0]),  32'(GD));
    rd("disp0_readback", A_DISP0, 32'h00000096);
    wr(A_DISP2, 32'hFFFFFF07);
    check("disp2_high", 32'(seg_high[20:14]), 32'(G0));
    check("disp2_low",  32'(seg_low[20:14]),  32'(G7));
    rd("disp2_readback", A_DISP2, 32'h7);
    wr(A_IDX11, 32'h55);
    rd("idx11_unmapped", A_IDX11, 32'h0);
    check("out_regs_after_idx11", 32'(out_regs), 32'h070096);

    // Debounce ch1: 0->5 with a one-cycle glitch, then a clean hold
    sw_in = {5'd5, 5'd0};
    for (int i = 0; i < DEB - 3; i++) rd("sw1_before_glitch", A_SW1, 32'h0);
    sw_in = {5'd0, 5'd0};
    rd("sw1_glitch", A_SW1, 32'h0);
    sw_in = {5'd5, 5'd0};
    for (int i = 0; i < DEB + 1; i++) rd("sw1_settling", A_SW1, 32'h0);
    rd("sw1_accepted", A_SW1, 32'h5);
    rd("status_ch1", A_STATUS, 32'h2);
    rd("status_cleared", A_STATUS, 32'h0);

    // Ch0 change lands on the same edge as a status read: bit must survive
    sw_in = {5'd5, 5'd3};
    for (int i = 0; i < DEB; i++) rd("sw0_settling", A_SW0, 32'h0);
    rd("status_in_landing_cycle", A_STATUS, 32'h0);
    rd("status_ch0_kept", A_STATUS, 32'h1);
    rd("status_ch0_cleared", A_STATUS, 32'h0);
    rd("sw0_accepted", A_SW0, 32'h3);

    // Unmapped read and ignored write to an input slot
    rd("idx20_unmapped", A_IDX20, 32'h0);
    wr(A_SW0, 32'h1F);
    rd("sw0_after_write", A_SW0, 32'h3);
    rd("sw1_final", A_SW1, 32'h5);

    repeat (2) cycle();
    check("final_rd_valid", 32'(rd_valid), 32'h0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
